// File: rtl/tis_link_pkg.sv
// Shared types for the inter-node link: lane state encoding, word type and counter width.
package tis_link_pkg;

  localparam int WORD_W     = 11;
  localparam int LINK_CNT_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DONE  = 2'd2
  } link_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LINK_CNT_W-1:0] sat_inc(input logic [LINK_CNT_W-1:0] v);
    return (v == {LINK_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dir_port.sv
// One direction port between a node and a link; node drives writes/acks, link drives reads/write-acks.
interface dir_port #(
  parameter int WORD_W = 11
);
  logic              wen;
  logic [WORD_W-1:0] wdata;
  logic              rack;
  logic              ren;
  logic [WORD_W-1:0] rdata;
  logic              wack;

  modport node (output wen, output wdata, output rack,
                input  ren, input  rdata, input  wack);
  modport link (input  wen, input  wdata, input  rack,
                output ren, output rdata, output wack);
endinterface

// File: rtl/link_lane.sv
// One direction of the link: single-word holding register with blocking-write handshake.
// Optional stall/transfer counters are built when TIS_LINK_STATS_EN is defined.
module link_lane
  import tis_link_pkg::*;
#(
  parameter int WORD_W = 11
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  wen_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  rack_i,
  output logic                  ren_o,
  output logic [WORD_W-1:0]     rdata_o,
  output logic                  wack_o
`ifdef TIS_LINK_STATS_EN
  ,
  output logic [LINK_CNT_W-1:0] stall_o,
  output logic [LINK_CNT_W-1:0] xfer_o
`endif
);

  link_state_t       state_q;
  logic [WORD_W-1:0] buf_q;
  logic              ren_q;
  logic              wack_q;

  // buf_q is cleared on leaving FULL so it doubles as the zero-when-idle rdata.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      ren_q   <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (wen_i) begin
            state_q <= FULL;
            buf_q   <= wdata_i;
            ren_q   <= 1'b1;
          end
        end
        FULL: begin
          if (rack_i) begin
            state_q <= DONE;
            buf_q   <= '0;
            ren_q   <= 1'b0;
            wack_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= EMPTY;
          wack_q  <= 1'b0;
        end
        default: begin
          state_q <= EMPTY;
          buf_q   <= '0;
          ren_q   <= 1'b0;
          wack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ren_o   = ren_q;
  assign rdata_o = buf_q;
  assign wack_o  = wack_q;

`ifdef TIS_LINK_STATS_EN
  logic [LINK_CNT_W-1:0] stall_q;
  logic [LINK_CNT_W-1:0] xfer_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else if (state_q == FULL) begin
      if (rack_i) xfer_q  <= sat_inc(xfer_q);
      else        stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_o = stall_q;
  assign xfer_o  = xfer_q;
`endif

endmodule

// File: rtl/tis_link.sv
// Point-to-point channel between two node direction ports: two independent lanes (A->B, B->A).
// Define TIS_LINK_STATS_EN to add per-lane stall and transfer counters.
module tis_link
  import tis_link_pkg::*;
#(
  parameter int WORD_W = tis_link_pkg::WORD_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  dir_port.link                 a,
  dir_port.link                 b
`ifdef TIS_LINK_STATS_EN
  ,
  output logic [LINK_CNT_W-1:0] stall_ab,
  output logic [LINK_CNT_W-1:0] stall_ba,
  output logic [LINK_CNT_W-1:0] xfer_ab,
  output logic [LINK_CNT_W-1:0] xfer_ba
`endif
);

  // A writes, B reads.
  link_lane #(.WORD_W(WORD_W)) u_lane_ab (
    .clk_i   (CLK),
    .srst_i  (RST),
    .wen_i   (a.wen),
    .wdata_i (a.wdata),
    .rack_i  (b.rack),
    .ren_o   (b.ren),
    .rdata_o (b.rdata),
    .wack_o  (a.wack)
`ifdef TIS_LINK_STATS_EN
    ,
    .stall_o (stall_ab),
    .xfer_o  (xfer_ab)
`endif
  );

  // B writes, A reads.
  link_lane #(.WORD_W(WORD_W)) u_lane_ba (
    .clk_i   (CLK),
    .srst_i  (RST),
    .wen_i   (b.wen),
    .wdata_i (b.wdata),
    .rack_i  (a.rack),
    .ren_o   (a.ren),
    .rdata_o (a.rdata),
    .wack_o  (b.wack)
`ifdef TIS_LINK_STATS_EN
    ,
    .stall_o (stall_ba),
    .xfer_o  (xfer_ba)
`endif
  );

endmodule

// File: tb/tb_tis_link.sv
// Directed bench for tis_link: latency, stalls, concurrency, reset abort, held wen, counters.
module tb_tis_link;
  import tis_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dir_port #(.WORD_W(WORD_W)) a_if ();
  dir_port #(.WORD_W(WORD_W)) b_if ();

`ifdef TIS_LINK_STATS_EN
  logic [LINK_CNT_W-1:0] stall_ab, stall_ba, xfer_ab, xfer_ba;
`endif

  tis_link #(.WORD_W(WORD_W)) dut (
    .CLK (clk),
    .RST (rst),
    .a   (a_if),
    .b   (b_if)
`ifdef TIS_LINK_STATS_EN
    ,
    .stall_ab (stall_ab),
    .stall_ba (stall_ba),
    .xfer_ab  (xfer_ab),
    .xfer_ba  (xfer_ba)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_if.wen = 1'b0; a_if.wdata = '0; a_if.rack = 1'b0;
    b_if.wen = 1'b0; b_if.wdata = '0; b_if.rack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Test 1: basic A->B transfer latency
    check_eq("rst_a_ren",   a_if.ren,   0);
    check_eq("rst_b_ren",   b_if.ren,   0);
    check_eq("rst_b_rdata", b_if.rdata, 0);
    check_eq("rst_a_wack",  a_if.wack,  0);
    check_eq("rst_b_wack",  b_if.wack,  0);
    a_if.wen = 1'b1; a_if.wdata = 11'd42;
    tick();                                   // c1
    a_if.wen = 1'b0;
    check_eq("t1_c1_b_ren",   b_if.ren,   1);
    check_eq("t1_c1_b_rdata", b_if.rdata, 42);
    check_eq("t1_c1_a_wack",  a_if.wack,  0);
    check_eq("t1_c1_a_ren",   a_if.ren,   0);
    b_if.rack = 1'b1;
    tick();                                   // c2
    b_if.rack = 1'b0;
    check_eq("t1_c2_a_wack",  a_if.wack,  1);
    check_eq("t1_c2_b_ren",   b_if.ren,   0);
    check_eq("t1_c2_b_rdata", b_if.rdata, 0);
    tick();                                   // c3
    check_eq("t1_c3_a_wack",  a_if.wack,  0);
    $display("test 1: A->B 42 transfer done");

    // Test 2: stalled reader, writer data changes ignored
    do_reset();
    a_if.wen = 1'b1; a_if.wdata = 11'h419;
    tick();
    a_if.wen = 1'b0; a_if.wdata = 11'h123;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_stall_rdata", b_if.rdata, 11'h419);
      check_eq("t2_stall_ren",   b_if.ren,   1);
      check_eq("t2_stall_wack",  a_if.wack,  0);
      tick();
    end
    check_eq("t2_c6_rdata", b_if.rdata, 11'h419);
    b_if.rack = 1'b1;
    tick();
    b_if.rack = 1'b0;
    check_eq("t2_wack", a_if.wack, 1);
    tick();
    check_eq("t2_wack_off", a_if.wack, 0);
`ifdef TIS_LINK_STATS_EN
    check_eq("t2_stall_ab", stall_ab, 5);
    check_eq("t2_xfer_ab",  xfer_ab,  1);
    check_eq("t2_stall_ba", stall_ba, 0);
`endif
    $display("test 2: stalled 11'h419 transfer done");

    // Test 3: concurrent transfers in both directions
    do_reset();
    a_if.wen = 1'b1; a_if.wdata = 11'd7;
    b_if.wen = 1'b1; b_if.wdata = 11'd9;
    tick();
    a_if.wen = 1'b0; b_if.wen = 1'b0;
    check_eq("t3_b_rdata", b_if.rdata, 7);
    check_eq("t3_a_rdata", a_if.rdata, 9);
    a_if.rack = 1'b1; b_if.rack = 1'b1;
    tick();
    a_if.rack = 1'b0; b_if.rack = 1'b0;
    check_eq("t3_a_wack", a_if.wack, 1);
    check_eq("t3_b_wack", b_if.wack, 1);
    $display("test 3: concurrent 7/9 transfers done");

    // Test 4: reset while FULL discards the word
    do_reset();
    a_if.wen = 1'b1; a_if.wdata = 11'h055;
    tick();                                   // c1
    a_if.wen = 1'b0;
    check_eq("t4_c1_ren", b_if.ren, 1);
    rst = 1'b1;
    tick();                                   // c2
    rst = 1'b0;
    check_eq("t4_c2_ren",   b_if.ren,   0);
    check_eq("t4_c2_rdata", b_if.rdata, 0);
    check_eq("t4_c2_wack",  a_if.wack,  0);
    tick();                                   // c3
    check_eq("t4_c3_wack",  a_if.wack,  0);
    a_if.wen = 1'b1; a_if.wdata = 11'h2AA;
    tick();
    a_if.wen = 1'b0;
    check_eq("t4_new_rdata", b_if.rdata, 11'h2AA);
    b_if.rack = 1'b1;
    tick();
    b_if.rack = 1'b0;
    check_eq("t4_new_wack", a_if.wack, 1);
    $display("test 4: reset abort then fresh 11'h2AA transfer done");

    // Test 5: wen held through DONE, rack while EMPTY
    do_reset();
    a_if.wen = 1'b1; a_if.wdata = 11'd3;
    tick();                                   // c1
    check_eq("t5_c1_rdata", b_if.rdata, 3);
    b_if.rack = 1'b1;
    tick();                                   // c2, wen still high
    b_if.rack = 1'b0;
    check_eq("t5_c2_wack", a_if.wack, 1);
    tick();                                   // c3
    a_if.wen = 1'b0;
    check_eq("t5_c3_ren",  b_if.ren,  0);
    check_eq("t5_c3_wack", a_if.wack, 0);
    tick();
    check_eq("t5_c4_ren",  b_if.ren,  0);
`ifdef TIS_LINK_STATS_EN
    check_eq("t5_xfer_ab", xfer_ab, 1);
`endif
    b_if.rack = 1'b1;
    tick();
    tick();
    b_if.rack = 1'b0;
    check_eq("t5_rack_empty_ren",  b_if.ren,  0);
    check_eq("t5_rack_empty_wack", a_if.wack, 0);
    $display("test 5: held wen single transfer done");

`ifdef TIS_LINK_STATS_EN
    // Test 6: stall counter saturation
    do_reset();
    a_if.wen = 1'b1; a_if.wdata = 11'd1;
    tick();
    a_if.wen = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check_eq("t6_stall_sat", stall_ab, 16'hFFFF);
    check_eq("t6_ren",       b_if.ren, 1);
    b_if.rack = 1'b1;
    tick();
    b_if.rack = 1'b0;
    check_eq("t6_wack",      a_if.wack, 1);
    check_eq("t6_stall_hold", stall_ab, 16'hFFFF);
    $display("test 6: stall saturation done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
